display_scan_scheduler: RTL and testbench

//  Sequences the 8-digit common-anode 7-segment display from a double-buffered 32-bit word.
//  - One 4-bit nibble per digit; the downstream hex-to-7seg decoder drives segments from nibble.
//  - Divides clk into fixed per-digit time slots and inserts anti-ghosting dead time.
//  - Applies PWM brightness and per-digit enables.
//  - Accepts new display data through a req/ack handshake, applied only at frame boundaries.

---
 rtl/display_pkg.sv | 32 +++
 rtl/scan_slot_timer.sv | 48 ++++
 rtl/display_scan_scheduler.sv | 119 +++++++++++
 tb/tb_display_scan_scheduler.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared definitions for the 8-digit 7-segment scan scheduler.
//   NUM_DIGITS, ANODES_OFF, PWM_FULL : display-wide constants
//   phase_e                           : per-slot phase (dead time vs. lit)
//   onehot_low()                      : active-low anode pattern for one digit
//   lz_mask()                         : leading-zero suppress mask for a display word
package display_pkg;

  localparam int unsigned NUM_DIGITS = 8;
  localparam logic [7:0]  ANODES_OFF = 8'hFF;
  localparam logic [3:0]  PWM_FULL   = 4'hF;

  typedef enum logic {PH_BLANK, PH_ON} phase_e;

  function automatic logic [7:0] onehot_low(input logic [2:0] d);
    return ~(8'h01 << d);
  endfunction

  // Keep every digit at or below the most significant nonzero nibble; digit 0 always kept.
  function automatic logic [7:0] lz_mask(input logic [31:0] w);
    logic [7:0] m;
    logic       seen;
    m    = '0;
    seen = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      seen = seen | (w[4*i +: 4] != 4'h0);
      m[i] = seen;
    end
    m[0] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/scan_slot_timer.sv
// Slot and digit counters for the display scan.
//   clk, reset  : clock, asynchronous active-high reset
//   digit       : current digit index d (0..7)
//   slot_first  : s == 0 (first cycle of a digit slot)
//   frame_wrap  : d == 7 and s == SCAN_DIV-1 (frame boundary cycle)
//   phase       : PH_BLANK while s < BLANK_CYCLES, PH_ON otherwise
module scan_slot_timer
  import display_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 12500,
  parameter int unsigned BLANK_CYCLES = 100,
  parameter int unsigned SLOT_W       = 14
) (
  input  logic       clk,
  input  logic       reset,
  output logic [2:0] digit,
  output logic       slot_first,
  output logic       frame_wrap,
  output phase_e     phase
);

  logic [SLOT_W-1:0] s_q, s_d;
  logic [2:0]        d_q, d_d;
  logic              slot_wrap;

  always_comb begin
    slot_wrap = (s_q == SLOT_W'(SCAN_DIV - 1));
    s_d       = slot_wrap ? '0 : s_q + 1'b1;
    // 3-bit digit counter wraps 7 -> 0 on its own.
    d_d       = slot_wrap ? d_q + 3'd1 : d_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_q <= '0;
      d_q <= '0;
    end else begin
      s_q <= s_d;
      d_q <= d_d;
    end
  end

  assign digit      = d_q;
  assign slot_first = (s_q == '0);
  assign frame_wrap = slot_wrap && (d_q == 3'd7);
  assign phase      = (s_q < SLOT_W'(BLANK_CYCLES)) ? PH_BLANK : PH_ON;

endmodule

// File: rtl/display_scan_scheduler.sv
// Scans an 8-digit common-anode 7-segment display from a double-buffered 32-bit word.
//   clk, reset   : clock, asynchronous active-high reset
//   load_req/ack : requester holds load_req/load_data; ack pulses when the word is captured
//                  at a frame boundary
//   load_data    : new word, nibble d = bits [4d+3:4d], digit 0 rightmost
//   digit_en     : per-digit enable mask (live)
//   brightness   : PWM duty n/16 within ON phase, 15 = full on (live)
//   anodes       : active-low anode drives, at most one low
//   sel, nibble  : current digit index and its nibble for the downstream decoder
//   frame_start  : 1-cycle pulse at the start of the digit-0 slot
// Optional build macro LEADING_ZERO_BLANK_EN: suppresses digits above the most significant
// nonzero nibble of the captured word.
// All outputs are registered and lag the counter state by one cycle.
module display_scan_scheduler
  import display_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 12500,
  parameter int unsigned BLANK_CYCLES = 100,
  parameter int unsigned SLOT_W       = 14
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_req,
  input  logic [31:0] load_data,
  output logic        load_ack,
  input  logic [7:0]  digit_en,
  input  logic [3:0]  brightness,
  output logic [7:0]  anodes,
  output logic [2:0]  sel,
  output logic [3:0]  nibble,
  output logic        frame_start
);

  logic [2:0] digit;
  logic       slot_first;
  logic       frame_wrap;
  phase_e     phase;

  scan_slot_timer #(
    .SCAN_DIV     (SCAN_DIV),
    .BLANK_CYCLES (BLANK_CYCLES),
    .SLOT_W       (SLOT_W)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .digit      (digit),
    .slot_first (slot_first),
    .frame_wrap (frame_wrap),
    .phase      (phase)
  );

  logic [3:0]  p_q, p_d;
  logic [31:0] active_q, active_d;
  logic [7:0]  anodes_q, anodes_d;
  logic [2:0]  sel_q, sel_d;
  logic [3:0]  nibble_q, nibble_d;
  logic        load_ack_q, load_ack_d;
  logic        frame_start_q, frame_start_d;
  logic        capture;
  logic        pwm_on;
  logic [7:0]  en_eff;

`ifdef LEADING_ZERO_BLANK_EN
  logic [7:0] lz_q, lz_d;
`endif

  always_comb begin
    p_d      = p_q + 4'd1;
    capture  = frame_wrap && load_req;
    active_d = capture ? load_data : active_q;
`ifdef LEADING_ZERO_BLANK_EN
    lz_d     = capture ? lz_mask(load_data) : lz_q;
    en_eff   = digit_en & lz_q;
`else
    en_eff   = digit_en;
`endif
    pwm_on   = (brightness == PWM_FULL) || (p_q < brightness);
    anodes_d = (phase == PH_ON && en_eff[digit] && pwm_on) ? onehot_low(digit) : ANODES_OFF;
    sel_d         = digit;
    nibble_d      = active_q[{digit, 2'b00} +: 4];
    frame_start_d = slot_first && (digit == 3'd0);
    load_ack_d    = capture;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_q           <= '0;
      active_q      <= '0;
      anodes_q      <= ANODES_OFF;
      sel_q         <= '0;
      nibble_q      <= '0;
      load_ack_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      p_q           <= p_d;
      active_q      <= active_d;
      anodes_q      <= anodes_d;
      sel_q         <= sel_d;
      nibble_q      <= nibble_d;
      load_ack_q    <= load_ack_d;
      frame_start_q <= frame_start_d;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Nothing is suppressed until the first word is captured.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lz_q <= ANODES_OFF;
    else       lz_q <= lz_d;
  end
`endif

  assign anodes      = anodes_q;
  assign sel         = sel_q;
  assign nibble      = nibble_q;
  assign load_ack    = load_ack_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_display_scan_scheduler.sv
// Directed bench for display_scan_scheduler with SCAN_DIV = 10, BLANK_CYCLES = 2.
// Edge k after reset release shows the counter state c = k-1: s = c%10, d = (c/10)%8, p = c%16.
module tb_display_scan_scheduler;

  localparam int unsigned ScanDiv = 10;
  localparam int unsigned Blank   = 2;
  localparam int unsigned SlotW   = 4;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit Lz = 1'b1;
`else
  localparam bit Lz = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        load_req;
  logic [31:0] load_data;
  logic        load_ack;
  logic [7:0]  digit_en;
  logic [3:0]  brightness;
  logic [7:0]  anodes;
  logic [2:0]  sel;
  logic [3:0]  nibble;
  logic        frame_start;

  display_scan_scheduler #(
    .SCAN_DIV     (ScanDiv),
    .BLANK_CYCLES (Blank),
    .SLOT_W       (SlotW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .load_req    (load_req),
    .load_data   (load_data),
    .load_ack    (load_ack),
    .digit_en    (digit_en),
    .brightness  (brightness),
    .anodes      (anodes),
    .sel         (sel),
    .nibble      (nibble),
    .frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int k);
    while (cyc < k) step();
  endtask

  task automatic do_reset(input logic [7:0] en, input logic [3:0] br);
    reset      = 1'b1;
    load_req   = 1'b0;
    load_data  = '0;
    digit_en   = en;
    brightness = br;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    cyc   = 0;
  endtask

  // Loads a word at the first boundary (edge 80) and returns the edge its ack appeared on.
  task automatic load_word(input logic [31:0] w, output int ack_at);
    do_reset(8'hFF, 4'hF);
    run_to(5);
    load_req  = 1'b1;
    load_data = w;
    while (!load_ack && cyc < 200) step();
    ack_at   = load_ack ? cyc : -1;
    load_req = 1'b0;
  endtask

  typedef struct {
    logic [7:0] en;
    logic [3:0] br;
    int         k;
    logic [7:0] an;
    logic [2:0] sel;
    logic       fs;
  } vec_t;

  vec_t vecs [21];

  initial begin
    int ack_at;
    int cnt;
    int cnt2;
    int errs;

    vecs[0]  = '{8'hFF, 4'hF,  1, 8'hFF, 3'd0, 1'b1};
    vecs[1]  = '{8'hFF, 4'hF,  2, 8'hFF, 3'd0, 1'b0};
    vecs[2]  = '{8'hFF, 4'hF,  3, 8'hFE, 3'd0, 1'b0};
    vecs[3]  = '{8'hFF, 4'hF, 10, 8'hFE, 3'd0, 1'b0};
    vecs[4]  = '{8'hFF, 4'hF, 11, 8'hFF, 3'd1, 1'b0};
    vecs[5]  = '{8'hFF, 4'hF, 13, 8'hFD, 3'd1, 1'b0};
    vecs[6]  = '{8'hFF, 4'hF, 73, 8'h7F, 3'd7, 1'b0};
    vecs[7]  = '{8'hFF, 4'hF, 80, 8'h7F, 3'd7, 1'b0};
    vecs[8]  = '{8'hFF, 4'hF, 81, 8'hFF, 3'd0, 1'b1};
    vecs[9]  = '{8'hFF, 4'hF, 83, 8'hFE, 3'd0, 1'b0};
    vecs[10] = '{8'hFF, 4'h4,  3, 8'hFE, 3'd0, 1'b0};
    vecs[11] = '{8'hFF, 4'h4,  5, 8'hFF, 3'd0, 1'b0};
    vecs[12] = '{8'hFF, 4'h4, 17, 8'hFD, 3'd1, 1'b0};
    vecs[13] = '{8'hFF, 4'h4, 20, 8'hFD, 3'd1, 1'b0};
    vecs[14] = '{8'hFF, 4'h4, 21, 8'hFF, 3'd2, 1'b0};
    vecs[15] = '{8'hFF, 4'h0,  3, 8'hFF, 3'd0, 1'b0};
    vecs[16] = '{8'h0F, 4'hF, 43, 8'hFF, 3'd4, 1'b0};
    vecs[17] = '{8'h0F, 4'hF, 33, 8'hF7, 3'd3, 1'b0};
    vecs[18] = '{8'h0F, 4'hF, 80, 8'hFF, 3'd7, 1'b0};
    vecs[19] = '{8'h0F, 4'hF, 81, 8'hFF, 3'd0, 1'b1};
    vecs[20] = '{8'h0F, 4'h4, 35, 8'hF7, 3'd3, 1'b0};

    reset = 1'b1;
    load_req = 1'b0;
    load_data = '0;
    digit_en = 8'hFF;
    brightness = 4'hF;

    for (int i = 0; i < 21; i++) begin
      do_reset(vecs[i].en, vecs[i].br);
      run_to(vecs[i].k);
      chk($sformatf("vec%0d anodes", i), anodes, vecs[i].an);
      chk($sformatf("vec%0d sel", i), sel, vecs[i].sel);
      chk($sformatf("vec%0d frame_start", i), frame_start, vecs[i].fs);
    end

    // Reset mid-frame at digit 5.
    do_reset(8'hFF, 4'hF);
    run_to(55);
    chk("pre_reset anodes", anodes, 8'hDF);
    chk("pre_reset sel", sel, 3'd5);
    #2 reset = 1'b1;
    #1;
    chk("reset anodes", anodes, 8'hFF);
    chk("reset sel", sel, 3'd0);
    chk("reset nibble", nibble, 4'h0);
    chk("reset load_ack", load_ack, 1'b0);
    chk("reset frame_start", frame_start, 1'b0);
    @(posedge clk);
    #1;
    chk("reset held anodes", anodes, 8'hFF);
    @(negedge clk);
    reset = 1'b0;
    cyc = 0;
    run_to(1);
    chk("restart frame_start", frame_start, 1'b1);
    chk("restart sel", sel, 3'd0);
    run_to(3);
    chk("restart anodes", anodes, 8'hFE);

    // Frame pulse period, sel sequence and one-low invariant over three frames.
    do_reset(8'hFF, 4'hF);
    cnt = 0;
    errs = 0;
    cnt2 = 0;
    for (int k = 1; k <= 240; k++) begin
      step();
      if (frame_start) begin
        cnt++;
        if ((cyc - 1) % 80 != 0) errs++;
      end
      if (int'(sel) != ((cyc - 1) / 10) % 8) errs++;
      if ($countones(~anodes) > 1) cnt2++;
    end
    chk("frame_start count", cnt, 3);
    chk("sel/frame_start timing errors", errs, 0);
    chk("multiple anodes low", cnt2, 0);

    // PWM duty over one frame: 16 lit cycles at brightness 4, none at 0.
    do_reset(8'hFF, 4'h4);
    cnt = 0;
    for (int k = 1; k <= 80; k++) begin
      step();
      if (anodes != 8'hFF) cnt++;
    end
    chk("brightness4 lit cycles", cnt, 16);
    do_reset(8'hFF, 4'h0);
    cnt = 0;
    for (int k = 1; k <= 80; k++) begin
      step();
      if (anodes != 8'hFF) cnt++;
    end
    chk("brightness0 lit cycles", cnt, 0);

    // digit_en = 0F: high digits dark, low digits lit 8 cycles each.
    do_reset(8'h0F, 4'hF);
    cnt = 0;
    cnt2 = 0;
    for (int k = 1; k <= 80; k++) begin
      step();
      if (anodes[7:4] != 4'hF) cnt++;
      if (anodes[3:0] != 4'hF) cnt2++;
    end
    chk("en0F high digits lit", cnt, 0);
    chk("en0F low digits lit", cnt2, 32);

    // Load requested at d = 3: ack only after the frame boundary.
    do_reset(8'hFF, 4'hF);
    run_to(31);
    chk("pre_load nibble", nibble, 4'h0);
    load_req  = 1'b1;
    load_data = 32'h1234ABCD;
    while (!load_ack && cyc < 200) step();
    chk("load1 ack edge", load_ack ? cyc : -1, 80);
    load_req = 1'b0;
    step();
    chk("load1 ack one cycle", load_ack, 1'b0);
    chk("load1 d0 sel", sel, 3'd0);
    chk("load1 d0 nibble", nibble, 4'hD);
    // Request right after a boundary waits a full frame.
    load_req  = 1'b1;
    load_data = 32'h87654321;
    run_to(113);
    chk("load1 d3 nibble", nibble, 4'hA);
    chk("no early ack", load_ack, 1'b0);
    run_to(151);
    chk("load1 d7 sel", sel, 3'd7);
    chk("load1 d7 nibble", nibble, 4'h1);
    while (!load_ack && cyc < 300) step();
    chk("load2 ack edge", load_ack ? cyc : -1, 160);
    load_req = 1'b0;
    step();
    chk("load2 d0 nibble", nibble, 4'h1);

    // Reset wins over a boundary load.
    do_reset(8'hFF, 4'hF);
    run_to(79);
    load_req  = 1'b1;
    load_data = 32'hFFFFFFFF;
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
    chk("reset vs load ack", load_ack, 1'b0);
    @(negedge clk);
    load_req = 1'b0;
    reset = 1'b0;
    cyc = 0;
    step();
    chk("reset vs load nibble", nibble, 4'h0);

    // Leading-zero suppression (build dependent).
    load_word(32'h000000A0, ack_at);
    chk("lz A0 ack edge", ack_at, 80);
    run_to(83);
    chk("lz A0 digit0", anodes, 8'hFE);
    run_to(93);
    chk("lz A0 digit1", anodes, 8'hFD);
    run_to(103);
    chk("lz A0 digit2", anodes, Lz ? 8'hFF : 8'hFB);
    run_to(153);
    chk("lz A0 digit7", anodes, Lz ? 8'hFF : 8'h7F);
    load_word(32'h00000000, ack_at);
    chk("lz 0 ack edge", ack_at, 80);
    run_to(83);
    chk("lz 0 digit0", anodes, 8'hFE);
    run_to(93);
    chk("lz 0 digit1", anodes, Lz ? 8'hFF : 8'hFD);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
